fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Fetch sequencer for the IF program-counter stage.
- Drives the PC stage's advance enable and redirect inputs, and runs a one-outstanding request/response handshake with instruction memory.
- Buffers returned instructions in a small FIFO toward decode and cancels wrong-path fetches on an execute-stage branch redirect.
- Sits between the IF PC register, instruction SRAM interface, branch predictor and the ID stage.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- BUF_DEPTH, 2, instruction FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low; asserted when 0 at a rising clk edge
- pc  in  XLEN  current PC register value of the IF stage
- if_ready_go  out  1  advance enable to the IF stage
- if_br_taken  out  1  redirect strobe to the IF stage
- if_br_target  out  XLEN  redirect target to the IF stage
- pred_taken  in  1  predictor taken flag for the current pc
- pred_target  in  XLEN  predictor target for the current pc
- if_pred_taken  out  1  predictor taken flag forwarded to the IF stage
- if_pred_target  out  XLEN  predictor target forwarded to the IF stage
- ex_br_taken  in  1  execute-stage mispredict/redirect pulse
- ex_br_target  in  XLEN  correct target
- imem_req  out  1  instruction request valid
- imem_addr  out  XLEN  request address
- imem_addr_ok  in  1  request accepted
- imem_data_ok  in  1  response valid
- imem_rdata  in  XLEN  response instruction
- fs_valid  out  1  FIFO head valid toward ID
- fs_pc  out  XLEN  head PC
- fs_inst  out  XLEN  head instruction
- fs_pred_taken  out  1  head was predicted taken
- ds_allowin  in  1  ID pops the head when fs_valid & ds_allowin

Behaviour:
- Reset (reset==0 at edge):
  - state=BOOT; FIFO count, read pointer and write pointer = 0.
  - All outputs 0.
  - The IF stage's own active-high reset is driven by inversion at top level, so IF pc = 0xFFFFFFFC out of reset.
- States: BOOT, REQ, WAIT, CANCEL.
- BOOT:
  - Assert if_ready_go for one cycle, so pc advances 0xFFFFFFFC -> 0x0.
  - Next state is REQ.
- REQ:
  - imem_req=1 and imem_addr=pc only when (count + 0) < BUF_DEPTH; otherwise imem_req=0 and state holds.
  - On imem_req & imem_addr_ok:
    - Assert if_ready_go the same cycle (IF takes pred target or pc+4).
    - Latch req_pc=pc and req_pred=pred_taken.
    - Go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_data_ok: push {req_pc, imem_rdata, req_pred}, then go to REQ.
  - At most one request is outstanding.
- CANCEL:
  - imem_req=0.
  - On imem_data_ok: discard the data and go to REQ.
- Forwarding: if_pred_taken/if_pred_target = pred_taken/pred_target, combinationally, always.
- Redirect (ex_br_taken=1), takes priority over everything in that cycle:
  - if_br_taken=1, if_br_target=ex_br_target, if_ready_go=1, so IF loads the target next edge.
  - FIFO flushed (count and pointers cleared); a same-cycle pop or push is ignored; fs_valid forced 0 this cycle.
  - imem_req forced 0 this cycle, even in REQ; no new request.
  - Next state by current state:
    - WAIT without data_ok -> CANCEL.
    - WAIT with data_ok -> REQ, data dropped.
    - CANCEL without data_ok -> CANCEL.
    - CANCEL with data_ok -> REQ.
    - REQ or BOOT -> REQ.
- FIFO:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo BUF_DEPTH.
  - fs_* = head entry; fs_valid = (count != 0).
  - Issue gating guarantees a push never occurs when full; push into a full FIFO is a protocol error (assertion).
- if_ready_go is 0 in every case not listed above; pc holds.
- reset asserted mid-operation: state and FIFO cleared at that edge regardless of an in-flight request.
  - A late imem_data_ok arriving in REQ or BOOT is ignored.
  - Memory must be reset together with this block.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_cancel_cnt[31:0], both cleared on reset and wrapping at 2^32.
  - perf_stall_cnt increments each cycle fs_valid==0 outside BOOT.
  - perf_cancel_cnt increments on each discarded response (CANCEL data_ok, or redirect coincident with WAIT data_ok).
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Boot, memory with addr_ok and data_ok 1 cycle after request, ds_allowin=1 -> imem_addr sequence 0x0, 0x4, 0x8; fs_pc matches; one instruction per 2 cycles.
- ds_allowin=0 with BUF_DEPTH=2 -> exactly 2 entries buffered (pcs 0x0, 0x4), then imem_req stays 0; raising ds_allowin pops 0x0 first.
- ex_br_taken=1, ex_br_target=0x100 while in WAIT for pc 0x8 -> fetch returned for 0x8 is dropped, FIFO empties, next imem_addr=0x100.
- Redirect in the same cycle as data_ok for 0xC -> 0xC is not pushed, state REQ, next imem_addr=ex_br_target.
- pred_taken=1, pred_target=0x40 at pc 0x10 -> after addr_ok next imem_addr=0x40; entry 0x10 has fs_pred_taken=1.
- reset driven low in WAIT, then released -> BOOT pulse, first imem_addr=0x0, fs_valid=0; stale data_ok during BOOT is ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer between the IF PC stage, instruction memory and decode: one outstanding
// request, small in-order instruction FIFO, wrong-path cancel. Optional counters: FETCH_PERF_EN.
module fetch_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            if_ready_go,
    output logic            if_br_taken,
    output logic [XLEN-1:0] if_br_target,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_target,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_br_taken,
    input  logic [XLEN-1:0] ex_br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_addr_ok,
    input  logic            imem_data_ok,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            fs_valid,
    output logic [XLEN-1:0] fs_pc,
    output logic [XLEN-1:0] fs_inst,
    output logic            fs_pred_taken,
    input  logic            ds_allowin
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_cancel_cnt
`endif
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StWait,
        StCancel
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [XLEN-1:0]   req_pc_q;
    logic              req_pred_q;

    logic [XLEN-1:0]   buf_pc   [BUF_DEPTH];
    logic [XLEN-1:0]   buf_inst [BUF_DEPTH];
    logic              buf_pred [BUF_DEPTH];

    logic              push, pop, flush, latch, discard;
    logic              fifo_nonempty;
    logic              has_room;

    assign fifo_nonempty = (count_q != '0);
    assign has_room      = (count_q < CntW'(BUF_DEPTH));

    // Predictor result goes straight through to the PC stage.
    assign if_pred_taken  = pred_taken;
    assign if_pred_target = pred_target;

    always_comb begin
        state_d      = state_q;
        if_ready_go  = 1'b0;
        if_br_taken  = 1'b0;
        if_br_target = '0;
        imem_req     = 1'b0;
        imem_addr    = '0;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        latch        = 1'b0;
        discard      = 1'b0;

        if (reset) begin
            unique case (state_q)
                StBoot: begin
                    if_ready_go = 1'b1;
                    state_d     = StReq;
                end
                StReq: begin
                    if (has_room) begin
                        imem_req  = 1'b1;
                        imem_addr = pc;
                        if (imem_addr_ok) begin
                            if_ready_go = 1'b1;
                            latch       = 1'b1;
                            state_d     = StWait;
                        end
                    end
                end
                StWait: begin
                    if (imem_data_ok) begin
                        push    = 1'b1;
                        state_d = StReq;
                    end
                end
                StCancel: begin
                    if (imem_data_ok) begin
                        discard = 1'b1;
                        state_d = StReq;
                    end
                end
                default: state_d = StBoot;
            endcase

            pop = fifo_nonempty & ds_allowin;

            // A redirect overrides every other action of this cycle.
            if (ex_br_taken) begin
                if_br_taken  = 1'b1;
                if_br_target = ex_br_target;
                if_ready_go  = 1'b1;
                imem_req     = 1'b0;
                imem_addr    = '0;
                latch        = 1'b0;
                push         = 1'b0;
                pop          = 1'b0;
                flush        = 1'b1;
                case (state_q)
                    StWait: begin
                        discard = imem_data_ok;
                        state_d = imem_data_ok ? StReq : StCancel;
                    end
                    StCancel: state_d = imem_data_ok ? StReq : StCancel;
                    default:  state_d = StReq;
                endcase
            end
        end
    end

    assign fs_valid      = reset & fifo_nonempty & ~ex_br_taken;
    assign fs_pc         = fs_valid ? buf_pc[rd_ptr_q]   : '0;
    assign fs_inst       = fs_valid ? buf_inst[rd_ptr_q] : '0;
    assign fs_pred_taken = fs_valid & buf_pred[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StBoot;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            req_pc_q   <= '0;
            req_pred_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                req_pc_q   <= pc;
                req_pred_q <= pred_taken;
            end
            if (flush) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CntW'(1);
                    2'b01:   count_q <= count_q - CntW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr_q]   <= req_pc_q;
            buf_inst[wr_ptr_q] <= imem_rdata;
            buf_pred[wr_ptr_q] <= req_pred_q;
        end
    end

    // Issue gating must keep the FIFO from ever overflowing.
    assert property (@(posedge clk) disable iff (!reset) push |-> has_room);

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt  <= '0;
            perf_cancel_cnt <= '0;
        end else begin
            if (!fs_valid && (state_q != StBoot)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (discard) begin
                perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the IF PC register, a latency-programmable instruction memory
// and a one-entry predictor; scoreboards request addresses and entries delivered to decode.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        if_ready_go, if_br_taken, if_pred_taken;
    logic [31:0] if_br_target, if_pred_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        imem_req, imem_addr_ok, imem_data_ok;
    logic [31:0] imem_addr, imem_rdata;
    logic        fs_valid, fs_pred_taken, ds_allowin;
    logic [31:0] fs_pc, fs_inst;

    // Bench knobs
    logic        acc_en;
    int          mem_lat;
    logic        stale_dok;
    logic        pred_en;

    logic        busy = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.XLEN(32), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .if_ready_go    (if_ready_go),
        .if_br_taken    (if_br_taken),
        .if_br_target   (if_br_target),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_addr_ok   (imem_addr_ok),
        .imem_data_ok   (imem_data_ok),
        .imem_rdata     (imem_rdata),
        .fs_valid       (fs_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst),
        .fs_pred_taken  (fs_pred_taken),
        .ds_allowin     (ds_allowin)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
    endfunction

    // IF-stage PC register; its active-high reset is the inverse of reset.
    always @(posedge clk) begin
        if (!reset) pc <= 32'hFFFF_FFFC;
        else if (if_ready_go)
            pc <= if_br_taken ? if_br_target : (if_pred_taken ? if_pred_target : pc + 32'd4);
    end

    // Instruction memory: accepts immediately, answers mem_lat cycles later.
    always @(posedge clk) begin
        if (!reset) begin
            busy     <= 1'b0;
            wait_cnt <= 0;
        end else if (imem_req && imem_addr_ok) begin
            busy      <= 1'b1;
            wait_cnt  <= mem_lat;
            pend_addr <= imem_addr;
        end else if (busy) begin
            if (wait_cnt == 1) busy <= 1'b0;
            wait_cnt <= wait_cnt - 1;
        end
    end

    assign imem_addr_ok = imem_req & acc_en;
    assign imem_data_ok = (busy && (wait_cnt == 1)) || stale_dok;
    assign imem_rdata   = inst_of(pend_addr);
    assign pred_taken   = pred_en && (pc == 32'h10);
    assign pred_target  = pred_en ? 32'h40 : 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        ds;
        logic        acc;
        logic        rg;
        logic        req;
        logic [31:0] addr;
        logic        fsv;
        logic [31:0] fspc;
    } vec_t;

    ent_t        entq[$];
    logic [31:0] addrq[$];
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_ent(input logic [31:0] p, input logic pr);
        ent_t e;
        e.pc   = p;
        e.inst = inst_of(p);
        e.pred = pr;
        entq.push_back(e);
    endtask

    // Scoreboard: compare each accepted request and each decode pop against the queues.
    task automatic sample();
        ent_t e;
        @(negedge clk);
        if (imem_req && imem_addr_ok) begin
            if (addrq.size() == 0) chk("unexpected_request", imem_addr, 32'hFFFF_FFFF);
            else chk("imem_addr_seq", imem_addr, addrq.pop_front());
        end
        if (fs_valid && ds_allowin) begin
            if (entq.size() == 0) begin
                chk("unexpected_pop", fs_pc, 32'hFFFF_FFFF);
            end else begin
                e = entq.pop_front();
                chk("fs_pc", fs_pc, e.pc);
                chk("fs_inst", fs_inst, e.inst);
                chk("fs_pred_taken", 32'(fs_pred_taken), 32'(e.pred));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic end_scen(input string name);
        repeat (2) tick();
        chk({name, "_addr_left"}, 32'(addrq.size()), 32'd0);
        chk({name, "_ent_left"}, 32'(entq.size()), 32'd0);
        addrq.delete();
        entq.delete();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        acc_en       = 1'b1;
        ds_allowin   = 1'b1;
        mem_lat      = 1;
        stale_dok    = 1'b0;
        pred_en      = 1'b0;
        ex_br_taken  = 1'b0;
        ex_br_target = 32'h0;
        tick();
        sample();
        chk("rst_ready_go", 32'(if_ready_go), 32'd0);
        chk("rst_br_taken", 32'(if_br_taken), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_fs_valid", 32'(fs_valid), 32'd0);
        chk("rst_fs_pc", fs_pc, 32'd0);
        advance();
        reset = 1'b1;
    endtask

    initial begin
        //           ds    acc   rg    req   addr   fsv   fspc
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};  // BOOT pulse
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8};  // memory stops accepting
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0};

        // Streaming fetch, one instruction per two cycles.
        do_reset();
        addrq = '{32'h0, 32'h4, 32'h8};
        exp_ent(32'h0, 1'b0);
        exp_ent(32'h4, 1'b0);
        exp_ent(32'h8, 1'b0);
        for (int i = 0; i < 9; i++) begin
            ds_allowin = vecs[i].ds;
            acc_en     = vecs[i].acc;
            sample();
            chk($sformatf("vec%0d_ready_go", i), 32'(if_ready_go), 32'(vecs[i].rg));
            chk($sformatf("vec%0d_imem_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("vec%0d_imem_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_fs_valid", i), 32'(fs_valid), 32'(vecs[i].fsv));
            if (vecs[i].fsv) chk($sformatf("vec%0d_fs_pc", i), fs_pc, vecs[i].fspc);
            advance();
        end
        end_scen("stream");

        // Decode stalled: FIFO fills with two entries, then issue stops.
        do_reset();
        ds_allowin = 1'b0;
        addrq = '{32'h0, 32'h4};
        exp_ent(32'h0, 1'b0);
        exp_ent(32'h4, 1'b0);
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("full_imem_req", 32'(imem_req), 32'd0);
            chk("full_ready_go", 32'(if_ready_go), 32'd0);
            chk("full_fs_valid", 32'(fs_valid), 32'd1);
            chk("full_fs_pc", fs_pc, 32'h0);
            advance();
        end
        acc_en     = 1'b0;
        ds_allowin = 1'b1;
        repeat (2) tick();
        end_scen("full");

        // Redirect while waiting on a slow response for 0x8.
        do_reset();
        addrq = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_ent(32'h0, 1'b0);
        exp_ent(32'h100, 1'b0);
        repeat (4) tick();
        mem_lat    = 3;
        ds_allowin = 1'b0;
        repeat (2) tick();
        ex_br_taken  = 1'b1;
        ex_br_target = 32'h100;
        sample();
        chk("redir_br_taken", 32'(if_br_taken), 32'd1);
        chk("redir_br_target", if_br_target, 32'h100);
        chk("redir_ready_go", 32'(if_ready_go), 32'd1);
        chk("redir_fs_valid", 32'(fs_valid), 32'd0);
        chk("redir_imem_req", 32'(imem_req), 32'd0);
        advance();
        ex_br_taken = 1'b0;
        mem_lat     = 1;
        sample();
        chk("cancel_fs_valid", 32'(fs_valid), 32'd0);
        chk("cancel_imem_req", 32'(imem_req), 32'd0);
        advance();
        sample();
        chk("cancel_dok_imem_req", 32'(imem_req), 32'd0);
        chk("cancel_dok_fs_valid", 32'(fs_valid), 32'd0);
        advance();
        ds_allowin = 1'b1;
        sample();
        chk("post_cancel_req", 32'(imem_req), 32'd1);
        chk("post_cancel_addr", imem_addr, 32'h100);
        advance();
        acc_en = 1'b0;
        repeat (2) tick();
        end_scen("cancel");

        // Redirect coincident with the response for 0xC.
        do_reset();
        addrq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200};
        exp_ent(32'h0, 1'b0);
        exp_ent(32'h4, 1'b0);
        exp_ent(32'h8, 1'b0);
        exp_ent(32'h200, 1'b0);
        repeat (8) tick();
        ex_br_taken  = 1'b1;
        ex_br_target = 32'h200;
        sample();
        chk("coinc_br_taken", 32'(if_br_taken), 32'd1);
        chk("coinc_imem_req", 32'(imem_req), 32'd0);
        chk("coinc_ready_go", 32'(if_ready_go), 32'd1);
        advance();
        ex_br_taken = 1'b0;
        sample();
        chk("coinc_next_req", 32'(imem_req), 32'd1);
        chk("coinc_next_addr", imem_addr, 32'h200);
        chk("coinc_fs_valid", 32'(fs_valid), 32'd0);
        advance();
        acc_en = 1'b0;
        repeat (2) tick();
        end_scen("coinc");

        // Predicted-taken fetch at 0x10 jumps to 0x40.
        do_reset();
        pred_en = 1'b1;
        addrq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40};
        exp_ent(32'h0, 1'b0);
        exp_ent(32'h4, 1'b0);
        exp_ent(32'h8, 1'b0);
        exp_ent(32'hC, 1'b0);
        exp_ent(32'h10, 1'b1);
        exp_ent(32'h40, 1'b0);
        repeat (9) tick();
        sample();
        chk("pred_fwd_taken", 32'(if_pred_taken), 32'd1);
        chk("pred_fwd_target", if_pred_target, 32'h40);
        chk("pred_ready_go", 32'(if_ready_go), 32'd1);
        advance();
        sample();
        chk("pred_fwd_not_taken", 32'(if_pred_taken), 32'd0);
        advance();
        tick();
        acc_en = 1'b0;
        repeat (2) tick();
        end_scen("pred");

        // Reset in WAIT, reboot, stale response during BOOT.
        do_reset();
        mem_lat = 3;
        addrq = '{32'h0, 32'h0};
        exp_ent(32'h0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        sample();
        chk("midrst_ready_go", 32'(if_ready_go), 32'd0);
        chk("midrst_imem_req", 32'(imem_req), 32'd0);
        chk("midrst_fs_valid", 32'(fs_valid), 32'd0);
        advance();
        tick();
        reset     = 1'b1;
        stale_dok = 1'b1;
        mem_lat   = 1;
        sample();
        chk("reboot_ready_go", 32'(if_ready_go), 32'd1);
        chk("reboot_imem_req", 32'(imem_req), 32'd0);
        chk("reboot_fs_valid", 32'(fs_valid), 32'd0);
        advance();
        stale_dok = 1'b0;
        sample();
        chk("reboot_req", 32'(imem_req), 32'd1);
        chk("reboot_addr", imem_addr, 32'h0);
        chk("stale_not_pushed", 32'(fs_valid), 32'd0);
        advance();
        acc_en = 1'b0;
        tick();
        sample();
        chk("reboot_fs_valid", 32'(fs_valid), 32'd1);
        advance();
        sample();
        chk("reboot_drained", 32'(fs_valid), 32'd0);
        advance();
        end_scen("reboot");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
